cim_tile_scheduler: RTL and testbench

Job-level sequencer in front of the CiM BitNet core (the `Ctrl_top`/`Data_top` pair). It accepts a job command of T tiles, meters tile beats from the operand fetcher into the core's input handshake, and steers result beats from the core's output handshake to the result sink. It bounds the number of in-flight tiles with a credit counter and supports abort with clean drain. It signals job completion with a one-cycle pulse.

---
 rtl/cim_tile_scheduler.sv | 126 ++++++++++++
 tb/tb_cim_tile_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_tile_scheduler.sv
// Job-level sequencer for the CiM core: meters tile issue under a credit limit,
// steers result beats to the sink, and reports completion or abort.
module cim_tile_scheduler #(
    parameter int KT_W    = 8,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rst_n_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [KT_W-1:0] cmd_ntiles_i,
    input  logic            abort_i,
    input  logic            src_valid_i,
    output logic            src_ready_o,
    output logic [KT_W-1:0] src_tile_o,
    output logic            core_valid_in_o,
    input  logic            core_ready_in_i,
    input  logic            core_valid_out_i,
    output logic            core_ready_out_o,
    output logic            sink_valid_o,
    input  logic            sink_ready_i,
    output logic [KT_W-1:0] sink_tile_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            aborted_o
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, DONE} state_t;

    state_t          state, state_nxt;
    logic [KT_W-1:0] issued, results, ntiles;
    logic [KT_W-1:0] issued_nxt, results_nxt;
    logic [2:0]      outst, outst_nxt;
    logic            abrt;
    logic            iss_ok, iss_fire, res_fire, has_outst, cmd_fire;

    assign has_outst        = (outst != 3'd0);
    assign iss_ok           = (state == RUN) && (outst < 3'(MAX_OUT)) && (issued < ntiles);
    assign core_valid_in_o  = src_valid_i & iss_ok;
    assign src_ready_o      = core_ready_in_i & iss_ok;
    assign iss_fire         = src_valid_i & src_ready_o;

    // Results are only accepted against an outstanding tile; stray beats stall.
    assign sink_valid_o     = core_valid_out_i & has_outst;
    assign core_ready_out_o = sink_ready_i & has_outst;
    assign res_fire         = core_valid_out_i & core_ready_out_o;

    assign cmd_fire    = cmd_valid_i & (state == IDLE);
    assign issued_nxt  = iss_fire ? issued + KT_W'(1) : issued;
    assign results_nxt = res_fire ? results + KT_W'(1) : results;

    always_comb begin
        outst_nxt = outst;
        case ({iss_fire, res_fire})
            2'b10:   outst_nxt = outst + 3'd1;
            2'b01:   outst_nxt = outst - 3'd1;
            default: outst_nxt = outst;
        endcase
    end

    assign busy_o      = (state != IDLE);
    assign src_tile_o  = issued;
    assign sink_tile_o = results;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            issued  <= '0;
            results <= '0;
            ntiles  <= '0;
            outst   <= '0;
            abrt    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                ntiles  <= cmd_ntiles_i;
                issued  <= '0;
                results <= '0;
                outst   <= '0;
                abrt    <= 1'b0;
            end else begin
                issued  <= issued_nxt;
                results <= results_nxt;
                outst   <= outst_nxt;
                if (state == RUN && abort_i)
                    abrt <= 1'b1;
            end
        end
    end

    // Exit conditions look at next-cycle counter values so done follows the last fire directly.
    always_comb begin
        state_nxt   = state;
        cmd_ready_o = 1'b0;
        done_o      = 1'b0;
        aborted_o   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i)
                    state_nxt = (cmd_ntiles_i == '0) ? DONE : RUN;
            end
            RUN: begin
                if (abort_i)
                    state_nxt = FLUSH;
                else if (issued_nxt == ntiles)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (results_nxt == ntiles)
                    state_nxt = DONE;
            end
            FLUSH: begin
                if (outst_nxt == 3'd0)
                    state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                aborted_o = abrt;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cim_tile_scheduler.sv
// Scoreboard bench for cim_tile_scheduler: a two-cycle core model, directed jobs,
// expected result tiles and done flags queued ahead and checked by a monitor.
module tb_cim_tile_scheduler;

    localparam int KT_W = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [KT_W-1:0] cmd_ntiles = '0;
    logic            abort = 1'b0;
    logic            src_valid = 1'b0;
    logic            src_ready;
    logic [KT_W-1:0] src_tile;
    logic            core_valid_in;
    logic            core_ready_in = 1'b1;
    logic            core_valid_out;
    logic            core_ready_out;
    logic            sink_valid;
    logic            sink_ready = 1'b1;
    logic [KT_W-1:0] sink_tile;
    logic            busy, done, aborted;

    logic core_vout = 1'b0;
    logic spur = 1'b0;
    assign core_valid_out = core_vout | spur;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_tiles[$];
    int exp_done[$];
    int core_q[$];
    int cyc = 0;
    int iss_count = 0;
    int done_count = 0;
    logic iss_s = 1'b0;
    logic res_s = 1'b0;
    logic vin_seen = 1'b0;

    cim_tile_scheduler #(.KT_W(KT_W), .MAX_OUT(2)) dut (
        .clk              (clk),
        .rst_n_i          (rst_n),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_ntiles_i     (cmd_ntiles),
        .abort_i          (abort),
        .src_valid_i      (src_valid),
        .src_ready_o      (src_ready),
        .src_tile_o       (src_tile),
        .core_valid_in_o  (core_valid_in),
        .core_ready_in_i  (core_ready_in),
        .core_valid_out_i (core_valid_out),
        .core_ready_out_o (core_ready_out),
        .sink_valid_o     (sink_valid),
        .sink_ready_i     (sink_ready),
        .sink_tile_o      (sink_tile),
        .busy_o           (busy),
        .done_o           (done),
        .aborted_o        (aborted)
    );

    always #5 clk = ~clk;

    function automatic void check_output(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endfunction

    // Core model: each issued tile presents its result from the second edge after issue.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            core_q.delete();
            core_vout = 1'b0;
        end else begin
            cyc++;
            if (res_s && core_q.size() > 0)
                void'(core_q.pop_front());
            if (iss_s)
                core_q.push_back(cyc + 1);
            core_vout = (core_q.size() > 0) && (core_q[0] <= cyc);
        end
    end

    // Monitor: inputs only change just after posedge, so negedge values are the ones the next edge uses.
    always @(negedge clk) begin
        if (!rst_n) begin
            iss_s = 1'b0;
            res_s = 1'b0;
        end else begin
            iss_s = core_valid_in && core_ready_in;
            res_s = core_valid_out && core_ready_out;
            if (core_valid_in)
                vin_seen = 1'b1;
            if (iss_s)
                iss_count++;
            if (sink_valid && sink_ready) begin
                if (exp_tiles.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL sink_unexpected: got tile %0d, required no result", sink_tile);
                end else begin
                    check_output("sink_tile", int'(sink_tile), exp_tiles.pop_front());
                end
            end
            if (done) begin
                done_count++;
                if (exp_done.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL done_unexpected: got done=1, required done=0");
                end else begin
                    check_output("done_aborted", int'(aborted), exp_done.pop_front());
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int n);
        sync();
        cmd_valid  = 1'b1;
        cmd_ntiles = KT_W'(n);
        sync();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_issues(input int n);
        int k = 0;
        while (iss_count < n && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (iss_count < n) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL issue_timeout: got %0d issues, required %0d", iss_count, n);
        end
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_count < n && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_output("done_seen", done_count, n);
        @(negedge clk);
        #1;
        check_output("busy_after_done", int'(busy), 0);
        check_output("cmd_ready_after_done", int'(cmd_ready), 1);
    endtask

    initial begin
        #23;
        check_output("rst_cmd_ready", int'(cmd_ready), 1);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_aborted", int'(aborted), 0);
        check_output("rst_src_tile", int'(src_tile), 0);
        check_output("rst_sink_tile", int'(sink_tile), 0);
        check_output("rst_handshakes", int'({core_valid_in, src_ready, sink_valid, core_ready_out}), 0);
        sync();
        rst_n = 1'b1;

        $display("[TB] job T=4, all ready");
        for (int i = 0; i < 4; i++) exp_tiles.push_back(i);
        exp_done.push_back(0);
        iss_count = 0;
        src_valid = 1'b1;
        send_cmd(4);
        wait_done(1);
        check_output("t4_issues", iss_count, 4);
        check_output("t4_sink_tile_final", int'(sink_tile), 4);

        $display("[TB] spurious core result in IDLE");
        sync();
        spur = 1'b1;
        repeat (3) begin
            sync();
            check_output("spur_core_ready_out", int'(core_ready_out), 0);
            check_output("spur_sink_valid", int'(sink_valid), 0);
            check_output("spur_sink_tile", int'(sink_tile), 4);
        end
        spur = 1'b0;

        $display("[TB] job T=0");
        src_valid = 1'b0;
        vin_seen  = 1'b0;
        exp_done.push_back(0);
        send_cmd(0);
        check_output("t0_done_next_cycle", int'(done), 1);
        wait_done(2);
        check_output("t0_no_valid_in", int'(vin_seen), 0);

        $display("[TB] job T=5 with stalled sink");
        for (int i = 0; i < 5; i++) exp_tiles.push_back(i);
        exp_done.push_back(0);
        iss_count  = 0;
        sink_ready = 1'b0;
        src_valid  = 1'b1;
        send_cmd(5);
        repeat (10) sync();
        check_output("stall_src_ready", int'(src_ready), 0);
        check_output("stall_sink_valid", int'(sink_valid), 1);
        check_output("stall_issues", iss_count, 2);
        sink_ready = 1'b1;
        wait_done(3);
        check_output("t5_issues", iss_count, 5);
        check_output("t5_sink_tile_final", int'(sink_tile), 5);

        $display("[TB] job T=8 aborted after 3 issues");
        for (int i = 0; i < 3; i++) exp_tiles.push_back(i);
        exp_done.push_back(1);
        iss_count = 0;
        src_valid = 1'b1;
        send_cmd(8);
        wait_issues(3);
        sync();
        src_valid = 1'b0;
        abort     = 1'b1;
        sync();
        abort     = 1'b0;
        src_valid = 1'b1;
        wait_done(4);
        check_output("abort_issues", iss_count, 3);
        check_output("abort_results", int'(sink_tile), 3);

        $display("[TB] reset during T=6 job");
        for (int i = 0; i < 6; i++) exp_tiles.push_back(i);
        exp_done.push_back(0);
        iss_count = 0;
        src_valid = 1'b1;
        send_cmd(6);
        wait_issues(2);
        sync();
        src_valid = 1'b0;
        check_output("mid_busy", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("async_cmd_ready", int'(cmd_ready), 1);
        check_output("async_busy", int'(busy), 0);
        check_output("async_src_tile", int'(src_tile), 0);
        check_output("async_sink_tile", int'(sink_tile), 0);
        check_output("async_handshakes", int'({core_valid_in, src_ready, sink_valid, core_ready_out}), 0);
        exp_tiles.delete();
        exp_done.delete();
        sync();
        sync();
        rst_n = 1'b1;

        $display("[TB] job T=1 after reset");
        exp_tiles.push_back(0);
        exp_done.push_back(0);
        done_count = 0;
        iss_count  = 0;
        src_valid  = 1'b1;
        send_cmd(1);
        wait_done(1);
        check_output("t1_issues", iss_count, 1);
        check_output("t1_sink_tile_final", int'(sink_tile), 1);

        check_output("sb_tiles_empty", exp_tiles.size(), 0);
        check_output("sb_done_empty", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
